// File: rtl/hdpldadapt_rx_rm_pkg.sv
// Shared definitions for the RX rate-match controller.
//   rm_state_e    : controller state encoding, also exported on the testbus.
//   Tb*           : bit offsets of the fields packed into rm_testbus.
//   tb_state_lsb  : LSB of the state field, which sits just above fill_level.
package hdpldadapt_rx_rm_pkg;

  typedef enum logic [2:0] {
    RmIdle = 3'd0,
    RmFill = 3'd1,
    RmRun  = 3'd2,
    RmIns  = 3'd3,
    RmDel  = 3'd4
  } rm_state_e;

  localparam int unsigned TestbusW  = 20;
  localparam int unsigned TbDelBit  = 0;
  localparam int unsigned TbInsBit  = 1;
  localparam int unsigned TbFillLsb = 2;
  localparam int unsigned TbStateW  = 3;

  function automatic int unsigned tb_state_lsb(int unsigned awidth);
    return TbFillLsb + awidth + 1;
  endfunction

endpackage

// File: rtl/hdpldadapt_rx_rm_thresh.sv
// Hysteretic threshold comparator on the FIFO fill level.
//   SetBelow=1 : flag sets when fill <= lvl, clears when fill >= lvl + hyst.
//   SetBelow=0 : flag sets when fill >= lvl, clears when fill + hyst <= lvl.
//   Otherwise the flag holds; set wins if both conditions hold (hyst = 0).
// Ports: rd_clk, rd_rst_n (async), rd_srst_n (sync), fill, lvl, hyst -> flag.
module hdpldadapt_rx_rm_thresh #(
  parameter int unsigned AWIDTH   = 5,
  parameter bit          SetBelow = 1'b1,
  parameter bit          ResetVal = 1'b1
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  input  logic              rd_srst_n,
  input  logic [AWIDTH:0]   fill,
  input  logic [AWIDTH-1:0] lvl,
  input  logic [1:0]        hyst,
  output logic              flag
);

  // Two guard bits so lvl + hyst and fill + hyst cannot wrap.
  logic [AWIDTH+1:0] fill_x;
  logic [AWIDTH+1:0] lvl_x;
  logic [AWIDTH+1:0] hyst_x;
  logic              set_cond;
  logic              clr_cond;

  assign fill_x = {1'b0, fill};
  assign lvl_x  = {2'b00, lvl};
  assign hyst_x = {{AWIDTH{1'b0}}, hyst};

  always_comb begin
    set_cond = 1'b0;
    clr_cond = 1'b0;
    if (SetBelow) begin
      set_cond = (fill_x <= lvl_x);
      clr_cond = (fill_x >= lvl_x + hyst_x);
    end else begin
      set_cond = (fill_x >= lvl_x);
      clr_cond = (fill_x + hyst_x <= lvl_x);
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      flag <= ResetVal;
    end else if (!rd_srst_n) begin
      flag <= ResetVal;
    end else if (set_cond) begin
      flag <= 1'b1;
    end else if (clr_cond) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/hdpldadapt_rx_ratematch_ctrl.sv
// RX rate-match controller: derives FIFO occupancy from the read pointer and the
// synchronised write pointer, keeps hysteretic partially-empty/full status, and
// grants the insertion or deletion state machine (never both).
// Ports:
//   rd_clk, rd_rst_n (async), rd_srst_n (sync soft reset)
//   rd_ptr, wr_ptr_sync       : binary pointers, MSB is the wrap bit
//   rd_en, fifo_insert, fifo_delete : strobes from the insert/delete SMs
//   r_rm_en, r_pempty_lvl, r_pfull_lvl, r_hyst : configuration
//   cnt_clr                   : clears event counters and sticky flags
//   rd_empty, rd_pempty, rd_pfull, fill_level : registered status
//   ins_allow, del_allow      : grants
//   ins_cnt, del_cnt          : saturating event counters
//   underflow, overflow       : sticky errors
//   rm_testbus                : {pad, state, fill_level, ins_allow, del_allow}
module hdpldadapt_rx_ratematch_ctrl
  import hdpldadapt_rx_rm_pkg::*;
#(
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned CNTW   = 8
) (
  input  logic                rd_clk,
  input  logic                rd_rst_n,
  input  logic                rd_srst_n,
  input  logic [AWIDTH:0]     rd_ptr,
  input  logic [AWIDTH:0]     wr_ptr_sync,
  input  logic                rd_en,
  input  logic                fifo_insert,
  input  logic                fifo_delete,
  input  logic                r_rm_en,
  input  logic [AWIDTH-1:0]   r_pempty_lvl,
  input  logic [AWIDTH-1:0]   r_pfull_lvl,
  input  logic [1:0]          r_hyst,
  input  logic                cnt_clr,
  output logic                rd_empty,
  output logic                rd_pempty,
  output logic                rd_pfull,
  output logic                ins_allow,
  output logic                del_allow,
  output logic [AWIDTH:0]     fill_level,
  output logic [CNTW-1:0]     ins_cnt,
  output logic [CNTW-1:0]     del_cnt,
  output logic                underflow,
  output logic                overflow,
  output logic [TestbusW-1:0] rm_testbus
);

  localparam int unsigned StateLsb = tb_state_lsb(AWIDTH);

  rm_state_e       state;
  logic [AWIDTH:0] fill;
  logic            fill_over;

  // Modular subtraction handles pointer wrap for free.
  assign fill = wr_ptr_sync - rd_ptr;
  // fill > 2^AWIDTH: wrap bit set with any lower bit set.
  assign fill_over = fill[AWIDTH] & (|fill[AWIDTH-1:0]);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      fill_level <= '0;
      rd_empty   <= 1'b1;
    end else if (!rd_srst_n) begin
      fill_level <= '0;
      rd_empty   <= 1'b1;
    end else begin
      fill_level <= fill;
      rd_empty   <= (fill == '0);
    end
  end

  hdpldadapt_rx_rm_thresh #(
    .AWIDTH   (AWIDTH),
    .SetBelow (1'b1),
    .ResetVal (1'b1)
  ) u_pempty (
    .rd_clk    (rd_clk),
    .rd_rst_n  (rd_rst_n),
    .rd_srst_n (rd_srst_n),
    .fill      (fill),
    .lvl       (r_pempty_lvl),
    .hyst      (r_hyst),
    .flag      (rd_pempty)
  );

  hdpldadapt_rx_rm_thresh #(
    .AWIDTH   (AWIDTH),
    .SetBelow (1'b0),
    .ResetVal (1'b0)
  ) u_pfull (
    .rd_clk    (rd_clk),
    .rd_rst_n  (rd_rst_n),
    .rd_srst_n (rd_srst_n),
    .fill      (fill),
    .lvl       (r_pfull_lvl),
    .hyst      (r_hyst),
    .flag      (rd_pfull)
  );

  // Grants are registered alongside the state so they always match it.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state     <= RmIdle;
      ins_allow <= 1'b0;
      del_allow <= 1'b0;
    end else if (!rd_srst_n || !r_rm_en) begin
      state     <= RmIdle;
      ins_allow <= 1'b0;
      del_allow <= 1'b0;
    end else begin
      case (state)
        RmIdle: begin
          state     <= RmFill;
          ins_allow <= 1'b0;
          del_allow <= 1'b0;
        end
        RmFill: begin
          if (!rd_pempty && !rd_pfull) begin
            state <= RmRun;
          end
        end
        RmRun: begin
          if (rd_pempty) begin
            state     <= RmIns;
            ins_allow <= 1'b1;
          end else if (rd_pfull) begin
            state     <= RmDel;
            del_allow <= 1'b1;
          end
        end
        RmIns: begin
          if (!rd_pempty) begin
            state     <= RmRun;
            ins_allow <= 1'b0;
          end
        end
        RmDel: begin
          if (!rd_pfull) begin
            state     <= RmRun;
            del_allow <= 1'b0;
          end
        end
        default: begin
          state     <= RmIdle;
          ins_allow <= 1'b0;
          del_allow <= 1'b0;
        end
      endcase
    end
  end

  // Counters and sticky flags; insert/delete outside a grant are only counted.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      ins_cnt   <= '0;
      del_cnt   <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else if (!rd_srst_n || cnt_clr) begin
      ins_cnt   <= '0;
      del_cnt   <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (fifo_insert && (ins_cnt != '1)) begin
        ins_cnt <= ins_cnt + 1'b1;
      end
      if (fifo_delete && (del_cnt != '1)) begin
        del_cnt <= del_cnt + 1'b1;
      end
      if (rd_en && rd_empty) begin
        underflow <= 1'b1;
      end
      if (fill_over) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    rm_testbus                           = '0;
    rm_testbus[TbDelBit]                 = del_allow;
    rm_testbus[TbInsBit]                 = ins_allow;
    rm_testbus[TbFillLsb +: AWIDTH+1]    = fill_level;
    rm_testbus[StateLsb +: TbStateW]     = state;
  end

endmodule

// File: tb/tb_hdpldadapt_rx_ratematch_ctrl.sv
module tb_hdpldadapt_rx_ratematch_ctrl;
  import hdpldadapt_rx_rm_pkg::*;

  localparam int AW = 5;
  localparam int CW = 8;

  // Model modes, independent of the RTL encoding.
  localparam int MIdle = 0;
  localparam int MFill = 1;
  localparam int MRun  = 2;
  localparam int MIns  = 3;
  localparam int MDel  = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n = 1'b1;
  logic          rd_srst_n = 1'b1;
  logic [AW:0]   rd_ptr = '0;
  logic [AW:0]   wr_ptr_sync = '0;
  logic          rd_en = 1'b0;
  logic          fifo_insert = 1'b0;
  logic          fifo_delete = 1'b0;
  logic          r_rm_en = 1'b0;
  logic [AW-1:0] r_pempty_lvl = 5'd8;
  logic [AW-1:0] r_pfull_lvl = 5'd24;
  logic [1:0]    r_hyst = 2'd2;
  logic          cnt_clr = 1'b0;
  logic          rd_empty, rd_pempty, rd_pfull, ins_allow, del_allow;
  logic [AW:0]   fill_level;
  logic [CW-1:0] ins_cnt, del_cnt;
  logic          underflow, overflow;
  logic [19:0]   rm_testbus;

  int checks = 0;
  int failures = 0;
  bit run_cmp = 1'b0;

  // Model state
  int m_fill, m_mode, m_ins_cnt, m_del_cnt;
  bit m_empty, m_pe, m_pf, m_uf, m_of;

  hdpldadapt_rx_ratematch_ctrl #(.AWIDTH(AW), .CNTW(CW)) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .rd_srst_n    (rd_srst_n),
    .rd_ptr       (rd_ptr),
    .wr_ptr_sync  (wr_ptr_sync),
    .rd_en        (rd_en),
    .fifo_insert  (fifo_insert),
    .fifo_delete  (fifo_delete),
    .r_rm_en      (r_rm_en),
    .r_pempty_lvl (r_pempty_lvl),
    .r_pfull_lvl  (r_pfull_lvl),
    .r_hyst       (r_hyst),
    .cnt_clr      (cnt_clr),
    .rd_empty     (rd_empty),
    .rd_pempty    (rd_pempty),
    .rd_pfull     (rd_pfull),
    .ins_allow    (ins_allow),
    .del_allow    (del_allow),
    .fill_level   (fill_level),
    .ins_cnt      (ins_cnt),
    .del_cnt      (del_cnt),
    .underflow    (underflow),
    .overflow     (overflow),
    .rm_testbus   (rm_testbus)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int occupancy(input int wr, input int rd);
    return (wr + 64 - rd) % 64;
  endfunction

  function automatic int next_mode(input int mode, input bit en, input bit pe, input bit pf);
    if (!en) return MIdle;
    case (mode)
      MIdle:   return MFill;
      MFill:   return (!pe && !pf) ? MRun : MFill;
      MRun:    return pe ? MIns : (pf ? MDel : MRun);
      MIns:    return pe ? MIns : MRun;
      MDel:    return pf ? MDel : MRun;
      default: return MIdle;
    endcase
  endfunction

  function automatic logic [2:0] mode_code(input int mode);
    case (mode)
      MFill:   return RmFill;
      MRun:    return RmRun;
      MIns:    return RmIns;
      MDel:    return RmDel;
      default: return RmIdle;
    endcase
  endfunction

  function automatic bit next_pe(input int f, input bit cur);
    if (f <= int'(r_pempty_lvl)) return 1'b1;
    if (f >= int'(r_pempty_lvl) + int'(r_hyst)) return 1'b0;
    return cur;
  endfunction

  function automatic bit next_pf(input int f, input bit cur);
    if (f >= int'(r_pfull_lvl)) return 1'b1;
    if (f + int'(r_hyst) <= int'(r_pfull_lvl)) return 1'b0;
    return cur;
  endfunction

  always @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n || !rd_srst_n) begin
      m_fill    <= 0;
      m_empty   <= 1'b1;
      m_pe      <= 1'b1;
      m_pf      <= 1'b0;
      m_mode    <= MIdle;
      m_ins_cnt <= 0;
      m_del_cnt <= 0;
      m_uf      <= 1'b0;
      m_of      <= 1'b0;
    end else begin
      m_fill  <= occupancy(int'(wr_ptr_sync), int'(rd_ptr));
      m_empty <= (occupancy(int'(wr_ptr_sync), int'(rd_ptr)) == 0);
      m_pe    <= next_pe(occupancy(int'(wr_ptr_sync), int'(rd_ptr)), m_pe);
      m_pf    <= next_pf(occupancy(int'(wr_ptr_sync), int'(rd_ptr)), m_pf);
      m_mode  <= next_mode(m_mode, r_rm_en, m_pe, m_pf);
      if (cnt_clr) begin
        m_ins_cnt <= 0;
        m_del_cnt <= 0;
        m_uf      <= 1'b0;
        m_of      <= 1'b0;
      end else begin
        if (fifo_insert && m_ins_cnt < 255) m_ins_cnt <= m_ins_cnt + 1;
        if (fifo_delete && m_del_cnt < 255) m_del_cnt <= m_del_cnt + 1;
        if (rd_en && m_empty) m_uf <= 1'b1;
        if (occupancy(int'(wr_ptr_sync), int'(rd_ptr)) > 32) m_of <= 1'b1;
      end
    end
  end

  always @(negedge rd_clk) begin
    if (run_cmp) begin
      check("fill_level", 32'(fill_level), 32'(m_fill));
      check("rd_empty", 32'(rd_empty), 32'(m_empty));
      check("rd_pempty", 32'(rd_pempty), 32'(m_pe));
      check("rd_pfull", 32'(rd_pfull), 32'(m_pf));
      check("ins_allow", 32'(ins_allow), 32'(m_mode == MIns));
      check("del_allow", 32'(del_allow), 32'(m_mode == MDel));
      check("ins_cnt", 32'(ins_cnt), 32'(m_ins_cnt));
      check("del_cnt", 32'(del_cnt), 32'(m_del_cnt));
      check("underflow", 32'(underflow), 32'(m_uf));
      check("overflow", 32'(overflow), 32'(m_of));
      check("testbus", 32'(rm_testbus),
            32'({9'd0, mode_code(m_mode), 6'(m_fill), m_mode == MIns, m_mode == MDel}));
    end
  end

  task automatic cyc();
    @(posedge rd_clk);
    #2;
  endtask

  task automatic ptrs(input int wr, input int rd);
    wr_ptr_sync = 6'(wr);
    rd_ptr      = 6'(rd);
  endtask

  initial begin
    #1 rd_rst_n = 1'b0;
    run_cmp = 1'b1;
    repeat (3) cyc();
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_empty", 32'(rd_empty), 32'd1);
    check("rst_pempty", 32'(rd_pempty), 32'd1);
    check("rst_pfull", 32'(rd_pfull), 32'd0);
    check("rst_state", 32'(rm_testbus[10:8]), 32'd0);
    rd_rst_n = 1'b1;

    // Startup: fill 12 -> FILL then RUN
    ptrs(12, 0);
    r_rm_en = 1'b1;
    cyc();
    check("start_fill", 32'(fill_level), 32'd12);
    check("start_pempty", 32'(rd_pempty), 32'd0);
    check("start_state_fill", 32'(rm_testbus[10:8]), 32'(RmFill));
    cyc();
    check("start_state_run", 32'(rm_testbus[10:8]), 32'(RmRun));

    // Partially-empty hysteresis: 8 sets, 9 holds, 10 clears
    ptrs(8, 0);
    cyc();
    check("pe8_flag", 32'(rd_pempty), 32'd1);
    check("pe8_ins_not_yet", 32'(ins_allow), 32'd0);
    cyc();
    check("pe8_ins", 32'(ins_allow), 32'd1);
    ptrs(9, 0);
    cyc();
    check("pe9_hold", 32'(rd_pempty), 32'd1);
    ptrs(10, 0);
    cyc();
    check("pe10_clear", 32'(rd_pempty), 32'd0);
    cyc();
    check("pe10_ins_drop", 32'(ins_allow), 32'd0);
    check("pe10_run", 32'(rm_testbus[10:8]), 32'(RmRun));

    // Partially-full hysteresis: 25 sets, 23 holds, 22 clears
    ptrs(25, 0);
    cyc();
    check("pf25_flag", 32'(rd_pfull), 32'd1);
    cyc();
    check("pf25_del", 32'(del_allow), 32'd1);
    ptrs(23, 0);
    cyc();
    cyc();
    check("pf23_hold", 32'(del_allow), 32'd1);
    ptrs(22, 0);
    cyc();
    check("pf22_clear", 32'(rd_pfull), 32'd0);
    cyc();
    check("pf22_del_drop", 32'(del_allow), 32'd0);
    check("pf22_run", 32'(rm_testbus[10:8]), 32'(RmRun));

    // Pointer wrap: 0x02 - 0x3E = 4
    ptrs(2, 62);
    cyc();
    check("wrap_fill", 32'(fill_level), 32'd4);
    cyc();
    check("wrap_ins", 32'(ins_allow), 32'd1);

    // Saturating counter; deletes outside a grant are only counted
    fifo_insert = 1'b1;
    for (int i = 0; i < 300; i++) begin
      fifo_delete = (i < 3);
      cyc();
    end
    fifo_insert = 1'b0;
    fifo_delete = 1'b0;
    check("ins_sat", 32'(ins_cnt), 32'd255);
    check("del_cnt3", 32'(del_cnt), 32'd3);
    check("del_no_grant", 32'(del_allow), 32'd0);
    cnt_clr = 1'b1;
    fifo_insert = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    fifo_insert = 1'b0;
    check("clr_wins", 32'(ins_cnt), 32'd0);

    // Overflow (fill 40 > 32), then empty read -> underflow
    ptrs(40, 0);
    cyc();
    check("ovf_set", 32'(overflow), 32'd1);
    ptrs(0, 0);
    cyc();
    check("ovf_sticky", 32'(overflow), 32'd1);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    check("udf_set", 32'(underflow), 32'd1);
    cyc();
    check("udf_sticky", 32'(underflow), 32'd1);
    check("pre_rst_ins", 32'(ins_allow), 32'd1);

    // Async reset drops the grant without waiting for a clock edge
    #1 rd_rst_n = 1'b0;
    #1;
    check("async_ins_drop", 32'(ins_allow), 32'd0);
    check("async_udf_clr", 32'(underflow), 32'd0);
    check("async_state", 32'(rm_testbus[10:8]), 32'd0);
    cyc();
    rd_rst_n = 1'b1;

    // Reach INS again, then soft reset
    ptrs(16, 0);
    fifo_insert = 1'b1;
    cyc();
    cyc();
    ptrs(4, 0);
    cyc();
    cyc();
    fifo_insert = 1'b0;
    check("pre_srst_ins", 32'(ins_allow), 32'd1);
    check("pre_srst_cnt", 32'(ins_cnt), 32'd4);
    rd_srst_n = 1'b0;
    cyc();
    rd_srst_n = 1'b1;
    check("srst_ins", 32'(ins_allow), 32'd0);
    check("srst_cnt", 32'(ins_cnt), 32'd0);
    check("srst_fill", 32'(fill_level), 32'd0);
    check("srst_pempty", 32'(rd_pempty), 32'd1);

    // Disable goes to IDLE; pfull sets exactly at level
    ptrs(16, 0);
    cyc();
    cyc();
    cyc();
    check("en_run", 32'(rm_testbus[10:8]), 32'(RmRun));
    r_rm_en = 1'b0;
    ptrs(24, 0);
    cyc();
    check("dis_idle", 32'(rm_testbus[10:8]), 32'(RmIdle));
    check("pf24_set", 32'(rd_pfull), 32'd1);
    repeat (3) cyc();

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdpldadapt_rx_ratematch_ctrl.md
HDPLDADAPT_RX_RATEMATCH_CTRL -- requirements
Module: hdpldadapt_rx_ratematch_ctrl

Interface
REQ-001 Parameter AWIDTH, default 5, FIFO address width (depth 2^AWIDTH).
REQ-002 Parameter CNTW, default 8, event counter width.
REQ-003 rd_clk  input  1  read-domain clock.
REQ-004 rd_rst_n  input  1  reset, asynchronous, active-low; clock rd_clk.
REQ-005 rd_srst_n  input  1  synchronous soft reset, active-low.
REQ-006 rd_ptr  input  AWIDTH+1  binary read pointer, wrap bit is MSB.
REQ-007 wr_ptr_sync  input  AWIDTH+1  binary write pointer, already synchronized to rd_clk.
REQ-008 rd_en  input  1  FIFO read strobe from insertion SM.
REQ-009 fifo_insert  input  1  one-cycle insertion event pulse from insertion SM.
REQ-010 fifo_delete  input  1  one-cycle deletion event pulse from deletion SM.
REQ-011 r_rm_en  input  1  rate-match enable.
REQ-012 r_pempty_lvl, r_pfull_lvl  input  AWIDTH each  thresholds.
REQ-013 r_hyst  input  2  hysteresis in entries.
REQ-014 cnt_clr  input  1  synchronous clear of counters and sticky flags.
REQ-015 rd_empty, rd_pempty, rd_pfull  output  1 each  registered status.
REQ-016 ins_allow, del_allow  output  1 each  mutually exclusive grants to insert/delete SMs.
REQ-017 fill_level  output  AWIDTH+1  registered occupancy.
REQ-018 ins_cnt, del_cnt  output  CNTW each  saturating event counters.
REQ-019 underflow, overflow  output  1 each  sticky error flags.
REQ-020 rm_testbus  output  20  {9'd0, state[2:0], fill_level[5:0], ins_allow, del_allow} for AWIDTH=5, zero-padded otherwise.

Function
REQ-021 fill = (wr_ptr_sync - rd_ptr) mod 2^(AWIDTH+1); fill_level registered, 1-cycle latency.
REQ-022 rd_empty = (fill==0), registered same cycle as fill_level.
REQ-023 rd_pempty sets when fill <= r_pempty_lvl; clears when fill >= r_pempty_lvl + r_hyst; otherwise holds.
REQ-024 rd_pfull sets when fill >= r_pfull_lvl; clears when fill + r_hyst <= r_pfull_lvl; otherwise holds.
REQ-025 Threshold sums computed at AWIDTH+2 bits, no wrap.
REQ-026 States: RM_IDLE, RM_FILL, RM_RUN, RM_INS, RM_DEL.
REQ-027 RM_IDLE -> RM_FILL when r_rm_en=1; any state -> RM_IDLE when r_rm_en=0 (next cycle).
REQ-028 RM_FILL -> RM_RUN when rd_pempty=0 and rd_pfull=0.
REQ-029 RM_RUN -> RM_INS when rd_pempty=1; RM_RUN -> RM_DEL when rd_pfull=1; pempty has priority if both.
REQ-030 RM_INS -> RM_RUN when rd_pempty clears; RM_DEL -> RM_RUN when rd_pfull clears.
REQ-031 ins_allow=1 only in RM_INS; del_allow=1 only in RM_DEL; both registered, never simultaneously 1.
REQ-032 ins_cnt increments on fifo_insert, del_cnt on fifo_delete; saturate at all-ones; cnt_clr wins over increment.
REQ-033 underflow sets on rd_en && rd_empty; overflow sets when fill > 2^AWIDTH; clear only by cnt_clr or reset.
REQ-034 fifo_insert while ins_allow=0, or fifo_delete while del_allow=0: counted, no other effect.

Reset
REQ-035 rd_rst_n low: state=RM_IDLE, fill_level=0, rd_empty=1, rd_pempty=1, rd_pfull=0, ins_allow=del_allow=0, counters=0, sticky flags=0.
REQ-036 rd_srst_n low: same values as REQ-035, applied at rd_clk edge.
REQ-037 Reset mid-RM_INS/RM_DEL drops the grant in the same cycle (async) or next edge (soft).

Structure
REQ-038 State encodings and testbus field offsets in shared package hdpldadapt_rx_rm_pkg.
REQ-039 One sub-module hdpldadapt_rx_rm_thresh (hysteretic comparator), instantiated twice.

Verification (AWIDTH=5, pempty_lvl=8, pfull_lvl=24, hyst=2)
REQ-040 wr=12, rd=0, r_rm_en=1 -> RM_FILL then RM_RUN; fill_level=12, pempty=0, pfull=0.
REQ-041 fill drops 12->8 -> pempty=1, ins_allow=1 next cycle; fill 9 holds; fill 10 -> pempty=0, RM_RUN.
REQ-042 fill 25 -> del_allow=1; fill 23 holds; fill 22 -> RM_RUN, del_allow=0.
REQ-043 wr_ptr=6'h02, rd_ptr=6'h3E -> fill_level=4 (wrap correct).
REQ-044 300 fifo_insert pulses -> ins_cnt=255; cnt_clr with pulse -> ins_cnt=0.
REQ-045 rd_en at fill=0 -> underflow=1 sticky; rd_rst_n low in RM_INS -> ins_allow=0 immediately.
